rggen_bus_initiator: RTL

RGGEN_BUS_INITIATOR -- requirements
Module: rggen_bus_initiator

---
 rtl/rggen_rtl_pkg.sv | 29 ++
 rtl/rggen_bus_if.sv | 35 +++
 rtl/rggen_initiator_cmd_fifo.sv | 58 +++++
 rtl/rggen_bus_initiator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// ============================================================================
// Module   : rggen_rtl_pkg
// Desc     : Shared bus access/status encodings for the rggen bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_POSTED_WRITE = 2'b01,
      RGGEN_READ         = 2'b10,
      RGGEN_WRITE        = 2'b11
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

   function automatic logic rggen_is_error(input rggen_status status);
      return (status == RGGEN_SLAVE_ERROR) || (status == RGGEN_DECODE_ERROR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rggen_bus_if.sv
// ============================================================================
// Module   : rggen_bus_if
// Desc     : Single-outstanding register bus between initiator and target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rggen_bus_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int STROBE_WIDTH  = BUS_WIDTH / 8
) ();

   logic                              valid;
   rggen_rtl_pkg::rggen_access        access;
   logic [ADDRESS_WIDTH-1:0]          address;
   logic [BUS_WIDTH-1:0]              write_data;
   logic [STROBE_WIDTH-1:0]           strobe;
   logic                              ready;
   rggen_rtl_pkg::rggen_status        status;
   logic [BUS_WIDTH-1:0]              read_data;

   modport master (
      output valid, access, address, write_data, strobe,
      input  ready, status, read_data
   );

   modport slave (
      input  valid, access, address, write_data, strobe,
      output ready, status, read_data
   );

endinterface

`default_nettype wire

// File: rtl/rggen_initiator_cmd_fifo.sv
// ============================================================================
// Module   : rggen_initiator_cmd_fifo
// Desc     : Show-ahead command FIFO; extra pointer bit separates full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_initiator_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   output logic                     o_full,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int               c_PTR_W   = $clog2(DEPTH);
   localparam logic [c_PTR_W:0] c_PTR_ONE = 1;

   logic [c_PTR_W:0]  r_wr_ptr;
   logic [c_PTR_W:0]  r_rd_ptr;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic              w_push;
   logic              w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                    (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

   // Overflow/underflow requests are ignored rather than corrupting state.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/rggen_bus_initiator.sv
// ============================================================================
// Module   : rggen_bus_initiator
// Desc     : Queues commands and issues them one at a time on rggen_bus_if.
// Options  : RGGEN_BUS_INITIATOR_ERROR_COUNTER_EN adds a saturating error count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_bus_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int STROBE_WIDTH  = BUS_WIDTH / 8,
   parameter int CMD_DEPTH     = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  rggen_access              i_cmd_access,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
   input  logic [STROBE_WIDTH-1:0]  i_cmd_strobe,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output rggen_status              o_rsp_status,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_busy,
`ifdef RGGEN_BUS_INITIATOR_ERROR_COUNTER_EN
   input  logic                     i_error_count_clear,
   output logic [7:0]               o_error_count,
`endif
   rggen_bus_if.master              bus_if
);

   typedef logic [1:0] state_t;
   localparam state_t c_IDLE     = 2'd0;
   localparam state_t c_REQUEST  = 2'd1;
   localparam state_t c_RESPONSE = 2'd2;

   typedef struct packed {
      rggen_access                access;
      logic [ADDRESS_WIDTH-1:0]   address;
      logic [BUS_WIDTH-1:0]       write_data;
      logic [STROBE_WIDTH-1:0]    strobe;
   } cmd_t;

   state_t                       r_state;
   cmd_t                         r_cmd;
   rggen_status                  r_rsp_status;
   logic [BUS_WIDTH-1:0]         r_rsp_read_data;
   cmd_t                         w_cmd_in;
   cmd_t                         w_fifo_head;
   logic                         w_fifo_full;
   logic                         w_fifo_empty;
   logic                         w_fifo_pop;
   logic [$clog2(CMD_DEPTH):0]   w_fifo_count;
   logic                         w_is_read;

   assign w_cmd_in = {i_cmd_access, i_cmd_address, i_cmd_write_data, i_cmd_strobe};

   // The head is consumed either from IDLE or directly out of a completed
   // response, so back-to-back commands skip the IDLE bubble.
   assign w_fifo_pop = !w_fifo_empty &&
                       ((r_state == c_IDLE) || ((r_state == c_RESPONSE) && i_rsp_ready));

   rggen_initiator_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_cmd_valid),
      .i_data  (w_cmd_in),
      .o_full  (w_fifo_full),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= c_IDLE;
         r_cmd           <= '0;
         r_rsp_status    <= RGGEN_OKAY;
         r_rsp_read_data <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_fifo_pop) begin
                  r_cmd   <= w_fifo_head;
                  r_state <= c_REQUEST;
               end
            end
            c_REQUEST: begin
               if (bus_if.ready) begin
                  r_rsp_status    <= bus_if.status;
                  r_rsp_read_data <= bus_if.read_data;
                  r_state         <= c_RESPONSE;
               end
            end
            c_RESPONSE: begin
               if (i_rsp_ready) begin
                  if (w_fifo_pop) begin
                     r_cmd   <= w_fifo_head;
                     r_state <= c_REQUEST;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign w_is_read          = (r_cmd.access == RGGEN_READ);
   assign bus_if.valid       = (r_state == c_REQUEST);
   assign bus_if.access      = r_cmd.access;
   assign bus_if.address     = r_cmd.address;
   assign bus_if.write_data  = w_is_read ? '0 : r_cmd.write_data;
   assign bus_if.strobe      = w_is_read ? '0 : r_cmd.strobe;

   assign o_cmd_ready     = !w_fifo_full;
   assign o_rsp_valid     = (r_state == c_RESPONSE);
   assign o_rsp_status    = r_rsp_status;
   assign o_rsp_read_data = r_rsp_read_data;
   assign o_busy          = (w_fifo_count != '0) || (r_state != c_IDLE);

`ifdef RGGEN_BUS_INITIATOR_ERROR_COUNTER_EN
   logic [7:0] r_error_count;
   logic       w_error_capture;

   assign w_error_capture = (r_state == c_REQUEST) && bus_if.ready &&
                            rggen_is_error(bus_if.status);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_error_count_clear) begin
         r_error_count <= 8'd0;
      end else if (w_error_capture && (r_error_count != 8'hFF)) begin
         r_error_count <= r_error_count + 8'd1;
      end
   end

   assign o_error_count = r_error_count;
`endif

endmodule

`default_nettype wire
